// File: rtl/char_rstream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : char_rstream_pkg
// Brief   : Command codes and arbiter state encodings shared by the
//           char_rstream arbiter files.
// Revision: 1.0 - initial release
// ============================================================================
package char_rstream_pkg;

  localparam logic [1:0] CMD_NONE          = 2'd0;
  localparam logic [1:0] CMD_START         = 2'd1;
  localparam logic [1:0] CMD_GET_NEXT_BYTE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    GAP     = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker: first requester at or after
//           i_ptr (wrapping), returned as one-hot and as an index.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_pick,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0] cand;

  // One spare bit lets ptr+k exceed N before folding back, so non-power-of-2
  // client counts wrap correctly.
  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, i_ptr} + (IW+1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (!o_any && i_req[cand[IW-1:0]]) begin
        o_any                 = 1'b1;
        o_pick[cand[IW-1:0]]  = 1'b1;
        o_idx                 = cand[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/char_rstream_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : char_rstream_arbiter
// Brief   : Round-robin, hold-until-release arbiter sharing one char_rstream
//           engine among NUM_CLIENTS requesters. Optional grant watchdog is
//           enabled by defining ARB_WATCHDOG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module char_rstream_arbiter
  import char_rstream_pkg::*;
#(
  parameter int NUM_CLIENTS      = 2,
  parameter int M_AXI_ADDR_WIDTH = 32,
`ifdef ARB_WATCHDOG_EN
  parameter int WDOG_CYCLES      = 1024,
`endif
  parameter int IDX_WIDTH        = $clog2(NUM_CLIENTS)
) (
  input  logic                                   AXI_ACLK,
  input  logic                                   AXI_ARESET,
  input  logic [NUM_CLIENTS-1:0]                 REQ,
  input  logic [NUM_CLIENTS-1:0]                 RELEASE,
  output logic [NUM_CLIENTS-1:0]                 GRANT,
  input  logic [2*NUM_CLIENTS-1:0]               CLI_CMD,
  input  logic [M_AXI_ADDR_WIDTH*NUM_CLIENTS-1:0] CLI_ADDR,
  output logic [NUM_CLIENTS-1:0]                 CLI_VALID,
  output logic [7:0]                             CLI_DATA,
  output logic [1:0]                             STRM_CMD,
  output logic [M_AXI_ADDR_WIDTH-1:0]            STRM_ADDR,
  input  logic                                   STRM_VALID,
  input  logic [7:0]                             STRM_DATA
`ifdef ARB_WATCHDOG_EN
  ,
  output logic                                   WDOG_FIRE
`endif
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLIENTS - 1);

  arb_state_e                  state_q, state_d;
  logic [NUM_CLIENTS-1:0]      grant_q, grant_d;
  logic [IDX_WIDTH-1:0]        owner_q, owner_d;
  logic [IDX_WIDTH-1:0]        rr_ptr_q, rr_ptr_d;
  logic                        started_q, started_d;
  logic [1:0]                  strm_cmd_q, strm_cmd_d;
  logic [M_AXI_ADDR_WIDTH-1:0] strm_addr_q, strm_addr_d;

  logic [NUM_CLIENTS-1:0]      pick;
  logic [IDX_WIDTH-1:0]        pick_idx;
  logic                        pick_any;
  logic [1:0]                  own_cmd;
  logic [M_AXI_ADDR_WIDTH-1:0] own_addr;
  logic                        own_release;
  logic                        fwd;
  logic                        revoke;
  logic [IDX_WIDTH-1:0]        next_ptr;

  rr_pick #(
    .N  (NUM_CLIENTS),
    .IW (IDX_WIDTH)
  ) u_rr_pick (
    .i_req  (REQ),
    .i_ptr  (rr_ptr_q),
    .o_pick (pick),
    .o_idx  (pick_idx),
    .o_any  (pick_any)
  );

  // The grant vector is one-hot, so it directly selects the owner's command.
  always_comb begin
    own_cmd  = CMD_NONE;
    own_addr = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_q[i]) begin
        own_cmd  = CLI_CMD[2*i +: 2];
        own_addr = CLI_ADDR[M_AXI_ADDR_WIDTH*i +: M_AXI_ADDR_WIDTH];
      end
    end
  end

  assign own_release = |(RELEASE & grant_q);
  assign fwd         = (state_q == GRANTED) && (own_cmd != CMD_NONE) &&
                       !((own_cmd == CMD_GET_NEXT_BYTE) && !started_q);
  assign next_ptr    = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

`ifdef ARB_WATCHDOG_EN
  localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_fire_q, wdog_fire_d;
  logic              wdog_hit;

  assign wdog_hit = (state_q == GRANTED) && !fwd && !own_release &&
                    (wdog_cnt_q == WDOG_LAST);

  always_comb begin
    wdog_cnt_d  = '0;
    wdog_fire_d = wdog_hit;
    if ((state_q == GRANTED) && !fwd && !own_release && !wdog_hit)
      wdog_cnt_d = wdog_cnt_q + 1'b1;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      wdog_cnt_q  <= '0;
      wdog_fire_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_fire_q <= wdog_fire_d;
    end
  end

  assign revoke    = own_release | wdog_hit;
  assign WDOG_FIRE = wdog_fire_q;
`else
  assign revoke    = own_release;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    started_d   = started_q;
    strm_cmd_d  = CMD_NONE;
    strm_addr_d = strm_addr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d   = pick;
          owner_d   = pick_idx;
          started_d = 1'b0;
          state_d   = GRANTED;
        end
      end
      GRANTED: begin
        if (own_cmd == CMD_START) started_d = 1'b1;
        if (fwd) begin
          strm_cmd_d  = own_cmd;
          strm_addr_d = own_addr;
        end
        if (revoke) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      started_q   <= 1'b0;
      strm_cmd_q  <= CMD_NONE;
      strm_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      started_q   <= started_d;
      strm_cmd_q  <= strm_cmd_d;
      strm_addr_q <= strm_addr_d;
    end
  end

  assign GRANT     = grant_q;
  assign STRM_CMD  = strm_cmd_q;
  assign STRM_ADDR = strm_addr_q;
  assign CLI_VALID = {NUM_CLIENTS{STRM_VALID}} & grant_q;
  assign CLI_DATA  = STRM_DATA;

endmodule
`default_nettype wire

// File: tb/tb_char_rstream_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_char_rstream_arbiter
// Brief   : Directed self-checking bench for char_rstream_arbiter, two
//           clients; watchdog section active when ARB_WATCHDOG_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_char_rstream_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  rel;
  logic [1:0]  grant;
  logic [3:0]  cli_cmd;
  logic [63:0] cli_addr;
  logic [1:0]  cli_valid;
  logic [7:0]  cli_data;
  logic [1:0]  strm_cmd;
  logic [31:0] strm_addr;
  logic        strm_valid;
  logic [7:0]  strm_data;
`ifdef ARB_WATCHDOG_EN
  logic        wdog_fire;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  char_rstream_arbiter #(
    .NUM_CLIENTS      (2),
`ifdef ARB_WATCHDOG_EN
    .WDOG_CYCLES      (8),
`endif
    .M_AXI_ADDR_WIDTH (32)
  ) dut (
    .AXI_ACLK   (clk),
    .AXI_ARESET (rst),
    .REQ        (req),
    .RELEASE    (rel),
    .GRANT      (grant),
    .CLI_CMD    (cli_cmd),
    .CLI_ADDR   (cli_addr),
    .CLI_VALID  (cli_valid),
    .CLI_DATA   (cli_data),
    .STRM_CMD   (strm_cmd),
    .STRM_ADDR  (strm_addr),
    .STRM_VALID (strm_valid),
    .STRM_DATA  (strm_data)
`ifdef ARB_WATCHDOG_EN
    ,
    .WDOG_FIRE  (wdog_fire)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    rel        = '0;
    cli_cmd    = '0;
    cli_addr   = '0;
    strm_valid = 1'b0;
    strm_data  = '0;
    tick();
    tick();
    check_val("rst_grant", grant, 2'b00);
    check_val("rst_cmd", strm_cmd, 2'd0);
    check_val("rst_addr", strm_addr, 32'h0);
    strm_valid = 1'b1;
    #1;
    check_val("rst_cli_valid", cli_valid, 2'b00);
    strm_valid = 1'b0;
    rst = 1'b0;

    // First grant and a forwarded START
    req = 2'b01;
    tick();
    check_val("grant0", grant, 2'b01);
    cli_cmd[1:0]   = 2'd1;
    cli_addr[31:0] = 32'hC000_0000;
    tick();
    check_val("start_cmd", strm_cmd, 2'd1);
    check_val("start_addr", strm_addr, 32'hC000_0000);
    cli_cmd[1:0] = 2'd0;
    tick();
    check_val("cmd_pulse", strm_cmd, 2'd0);
    check_val("addr_hold", strm_addr, 32'hC000_0000);

    // Non-owner command ignored; valid/data routing
    cli_cmd[3:2] = 2'd2;
    tick();
    check_val("nonowner_cmd", strm_cmd, 2'd0);
    cli_cmd[3:2] = 2'd0;
    strm_valid = 1'b1;
    strm_data  = 8'h41;
    #1;
    check_val("cli_valid", cli_valid, 2'b01);
    check_val("cli_data", cli_data, 8'h41);
    strm_valid = 1'b0;

    // Release from non-owner ignored
    rel = 2'b10;
    tick();
    check_val("nonowner_rel", grant, 2'b01);
    rel = 2'b00;

    // Same-cycle GET_NEXT_BYTE and RELEASE, client 1 waiting
    req          = 2'b11;
    cli_cmd[1:0] = 2'd2;
    rel          = 2'b01;
    tick();
    check_val("rel_cmd_fwd", strm_cmd, 2'd2);
    check_val("gap_grant", grant, 2'b00);
    cli_cmd[1:0] = 2'd0;
    rel          = 2'b00;
    tick();
    check_val("idle_grant", grant, 2'b00);
    check_val("gap_cmd", strm_cmd, 2'd0);
    tick();
    check_val("grant1", grant, 2'b10);

    // GET_NEXT_BYTE before START is dropped
    cli_cmd[3:2]    = 2'd2;
    cli_addr[63:32] = 32'h1234_5678;
    tick();
    check_val("gnb_dropped", strm_cmd, 2'd0);
    cli_cmd[3:2] = 2'd1;
    tick();
    check_val("start1_cmd", strm_cmd, 2'd1);
    check_val("start1_addr", strm_addr, 32'h1234_5678);
    cli_cmd[3:2] = 2'd2;
    tick();
    check_val("gnb1_cmd", strm_cmd, 2'd2);
    cli_cmd[3:2] = 2'd0;
    tick();
    check_val("gnb1_clear", strm_cmd, 2'd0);

    // Reset mid-grant clears the pointer back to client 0
    rst = 1'b1;
    tick();
    check_val("mid_rst_grant", grant, 2'b00);
    check_val("mid_rst_cmd", strm_cmd, 2'd0);
    check_val("mid_rst_addr", strm_addr, 32'h0);
    rst = 1'b0;
    tick();
    check_val("post_rst_grant", grant, 2'b01);

    // Release with REQ still held: client 0 goes to the back
    rel = 2'b01;
    tick();
    check_val("rr_gap0", grant, 2'b00);
    rel = 2'b00;
    tick();
    check_val("rr_idle0", grant, 2'b00);
    tick();
    check_val("rr_grant1", grant, 2'b10);
    rel = 2'b10;
    tick();
    check_val("rr_gap1", grant, 2'b00);
    rel = 2'b00;
    tick();
    tick();
    check_val("rr_wrap0", grant, 2'b01);

`ifdef ARB_WATCHDOG_EN
    // Silent owner: revoked after 8 idle granted cycles
    repeat (7) tick();
    check_val("wdog_hold", grant, 2'b01);
    check_val("wdog_quiet", wdog_fire, 1'b0);
    tick();
    check_val("wdog_revoke", grant, 2'b00);
    check_val("wdog_fire", wdog_fire, 1'b1);
    tick();
    check_val("wdog_pulse", wdog_fire, 1'b0);
    tick();
    check_val("wdog_next", grant, 2'b10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
